// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared types, constants and anode helper for the digit scanner
package scanner_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Widest digit row the anode helper can describe.
    localparam int MAX_DIGITS = 32;

    // One-hot select for digit position i; callers truncate to their row width.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int unsigned i);
        return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << i;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - slot prescaler producing one tick every PRESCALE enabled cycles
module tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;

    assign tick = en && (pcnt == PW'(PRESCALE - 1));

    // Count enabled cycles, wrap on the tick, freeze while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - multiplexed BCD digit scanner; SCANNER_LZ_BLANK_EN enables leading-zero blanking
module bcd_digit_scanner
    import scanner_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    output bcd_t                  digit_bcd,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int IW = $clog2(DIGITS);

    logic                tick;
    logic                boundary;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp_r;
    logic [4*DIGITS-1:0] pend_r;
    logic                pend_v;
    bcd_t                nib;
    logic                lz_dark;
    logic                dark;
    logic [DIGITS-1:0]   sel_oh;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign boundary = tick && (idx == IW'(DIGITS - 1));
    assign nib      = disp_r[{idx, 2'b00} +: 4];
    assign sel_oh   = DIGITS'(anode_onehot(32'(idx)));

`ifdef SCANNER_LZ_BLANK_EN
    // A nonzero slot is dark when it and everything above it is zero.
    assign lz_dark = (idx != '0) && ((disp_r >> {idx, 2'b00}) == '0);
`else
    assign lz_dark = 1'b0;
`endif

    assign dark = !en || (nib > BCD_MAX) || lz_dark;

    // Step the slot index on each prescaler tick, wrapping after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= boundary ? '0 : idx + IW'(1);
        end
    end

    // Double buffer: loads land in pend_r, displayed value swaps only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r <= '0;
            pend_r <= '0;
            pend_v <= 1'b0;
        end else if (load && boundary) begin
            disp_r <= digits_in;
            pend_r <= digits_in;
            pend_v <= 1'b0;
        end else if (load) begin
            pend_r <= digits_in;
            pend_v <= 1'b1;
        end else if (boundary && pend_v) begin
            disp_r <= pend_r;
            pend_v <= 1'b0;
        end
    end

    // Register the slot outputs together so digit, anode and blank never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_bcd  <= '0;
            anode_n    <= '1;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            digit_bcd  <= nib;
            anode_n    <= dark ? '1 : ~sel_oh;
            blank      <= dark;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - scoreboard bench for bcd_digit_scanner (DIGITS=4, PRESCALE=4)
module tb_bcd_digit_scanner;

    typedef logic [8:0] disp_state_t;   // {anode_n[3:0], blank, digit_bcd[3:0]}

    localparam disp_state_t RST_STATE = {4'b1111, 1'b1, 4'h0};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_bcd;
    logic [3:0]  anode_n;
    logic        blank;
    logic        frame_done;

    int n_checks;
    int n_pass;
    int fd_cnt;
    int fd_wide;
    logic fd_prev;

    disp_state_t exp_q[$];
    disp_state_t last_pushed;

    bcd_digit_scanner #(
        .DIGITS   (4),
        .PRESCALE (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .digit_bcd  (digit_bcd),
        .anode_n    (anode_n),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic disp_state_t slot_state(input logic [15:0] v, input int i);
        logic [3:0]  nib;
        logic [3:0]  oh;
        logic        dk;
        logic [15:0] upper;
        nib   = 4'((v >> (4 * i)) & 16'hF);
        upper = v >> (4 * i);
        dk    = (nib > 4'd9);
`ifdef SCANNER_LZ_BLANK_EN
        if (i > 0 && upper == 16'h0) dk = 1'b1;
`endif
        oh = 4'b0001 << i;
        return dk ? {4'b1111, 1'b1, nib} : {~oh, 1'b0, nib};
    endfunction

    task automatic push_state(input disp_state_t s);
        if (s !== last_pushed) exp_q.push_back(s);
        last_pushed = s;
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) push_state(slot_state(v, i));
    endtask

    // Monitor: every visible change of the display is one scoreboard entry.
    initial begin
        disp_state_t prev;
        disp_state_t cur;
        disp_state_t e;
        prev = RST_STATE;
        forever begin
            @(negedge clk);
            cur = {anode_n, blank, digit_bcd};
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL display_unexpected: got %b expected no change", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) $display("FAIL display_seq: got %b expected %b", cur, e);
                    else n_pass++;
                end
                prev = cur;
            end
        end
    end

    // frame_done pulse counter and width watch.
    initial begin
        fd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                if (fd_prev) fd_wide++;
            end
            fd_prev = frame_done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        fd_cnt      = 0;
        fd_wide     = 0;
        last_pushed = RST_STATE;
        rst_n       = 1'b0;
        en          = 1'b0;
        load        = 1'b0;
        digits_in   = 16'h0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_anode", 16'(anode_n), 16'hF);
        check("idle_blank", 16'(blank), 16'h1);
        check("idle_digit", 16'(digit_bcd), 16'h0);
        check("idle_fd", 16'(frame_done), 16'h0);
        check("idle_fd_cnt", 16'(fd_cnt), 16'd0);

        // Load while disabled: stays pending and dark.
        digits_in = 16'h4321; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("pend_dark_anode", 16'(anode_n), 16'hF);

        push_frame(16'h0000);
        push_frame(16'h4321);
        push_frame(16'h4321);
        push_frame(16'h9999);
        push_frame(16'h9999);
        push_frame(16'h6789);
        push_frame(16'h2468);
        push_frame(16'h00A5);
        push_state(slot_state(16'h0070, 0));
        push_state(slot_state(16'h0070, 1));
        push_state({4'b1111, 1'b1, 4'h0});
        push_state(slot_state(16'h0070, 2));
        push_state(slot_state(16'h0070, 3));
        push_state(slot_state(16'h0070, 0));
        push_state(slot_state(16'h0070, 1));
        push_state(slot_state(16'h0070, 2));
        push_state(RST_STATE);
        push_frame(16'h0000);
        push_frame(16'h0000);
        push_state({4'b1111, 1'b1, 4'h0});

        en = 1'b1;
        repeat (38) @(negedge clk);
        digits_in = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (27) @(negedge clk);
        digits_in = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        digits_in = 16'h6789; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (24) @(negedge clk);
        digits_in = 16'h2468; load = 1'b1;      // same cycle as the frame boundary
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        digits_in = 16'h00A5; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (15) @(negedge clk);
        digits_in = 16'h0070; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (19) @(negedge clk);
        check("fd_count_8_frames", 16'(fd_cnt), 16'd8);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("en_off_anode", 16'(anode_n), 16'hF);
        check("en_off_blank", 16'(blank), 16'h1);
        en = 1'b1;
        repeat (17) @(negedge clk);
        digits_in = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_anode", 16'(anode_n), 16'hF);
        check("rst_blank", 16'(blank), 16'h1);
        check("rst_digit", 16'(digit_bcd), 16'h0);
        check("rst_fd", 16'(frame_done), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        check("fd_single_cycle", 16'(fd_wide), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
